// File: rtl/opcode_fetch.sv
// Host command front end: assembles strobed host bytes into 16-bit opcodes,
// buffers them in a small FIFO and issues them to the core array under back-pressure.
module opcode_fetch #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        host_strobe,
    input  logic [7:0]  byte_in,
    input  logic        frame_sync,
    input  logic        core_busy,
    output logic [15:0] opcode,
    output logic        execute,
    output logic        fifo_full,
    output logic        overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    logic          s0, s1, s2;
    logic          byte_event;
    logic          phase;
    logic [7:0]    hi_byte;
    logic [15:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_next;
    logic          push, pop, push_ok;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    always_comb begin
        byte_event = s1 & ~s2;
        push       = byte_event & phase & ~frame_sync;
        pop        = (count != '0) & ~core_busy;
        push_ok    = push & ((count != FULL_COUNT) | pop);
        count_next = count;
        if (push_ok && !pop) begin
            count_next = count + CW'(1);
        end else if (pop && !push_ok) begin
            count_next = count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s0        <= 1'b0;
            s1        <= 1'b0;
            s2        <= 1'b0;
            phase     <= 1'b0;
            hi_byte   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            opcode    <= '0;
            execute   <= 1'b0;
            fifo_full <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            s0 <= host_strobe;
            s1 <= s0;
            s2 <= s1;

            // frame_sync has priority and swallows a coincident byte.
            if (frame_sync) begin
                phase   <= 1'b0;
                hi_byte <= '0;
            end else if (byte_event) begin
                if (!phase) begin
                    hi_byte <= byte_in;
                    phase   <= 1'b1;
                end else begin
                    phase   <= 1'b0;
                end
            end

            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                opcode <= mem[rd_ptr];
            end
            execute   <= pop;
            count     <= count_next;
            fifo_full <= (count_next == FULL_COUNT);
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push_ok) begin
            mem[wr_ptr] <= {hi_byte, byte_in};
        end
    end

endmodule

// File: tb/tb_opcode_fetch.sv
// Self-checking bench for opcode_fetch: table-driven opcode vectors plus hand-written
// sequences for latency, back-pressure, overflow, frame sync and push/pop at full.
module tb_opcode_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        host_strobe = 1'b0;
    logic [7:0]  byte_in = '0;
    logic        frame_sync = 1'b0;
    logic        core_busy = 1'b0;
    logic [15:0] opcode;
    logic        execute;
    logic        fifo_full;
    logic        overflow;

    int compared = 0;
    int mismatched = 0;
    int execCount = 0;
    logic [15:0] expQ[$];

    typedef struct {
        logic [7:0]  hiByte;
        logic [7:0]  loByte;
        logic [15:0] expOpcode;
    } vec_t;

    vec_t vecs[5];

    opcode_fetch #(.FIFO_DEPTH(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .host_strobe(host_strobe),
        .byte_in(byte_in),
        .frame_sync(frame_sync),
        .core_busy(core_busy),
        .opcode(opcode),
        .execute(execute),
        .fifo_full(fifo_full),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, actual, expected);
        end
    endtask

    // Scoreboard: every issued opcode must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && execute === 1'b1) begin
            execCount++;
            if (expQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_execute: got opcode 0x%04h, expected no issue", opcode);
            end else begin
                checkOutput("issued_opcode", opcode, expQ.pop_front());
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] b, input bit syncOnEvent);
        @(negedge clk);
        byte_in = b;
        host_strobe = 1'b1;
        @(negedge clk);
        @(negedge clk);
        host_strobe = 1'b0;
        if (syncOnEvent) frame_sync = 1'b1;
        @(negedge clk);
        frame_sync = 1'b0;
        @(negedge clk);
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst_n = 1'b0;
        host_strobe = 1'b1;
        byte_in = 8'hEE;
        @(negedge clk);
        host_strobe = 1'b0;
        @(negedge clk);
        checkOutput("reset_opcode", opcode, 16'h0000);
        checkOutput("reset_execute", {15'b0, execute}, 16'h0);
        checkOutput("reset_fifo_full", {15'b0, fifo_full}, 16'h0);
        checkOutput("reset_overflow", {15'b0, overflow}, 16'h0);
        expQ.delete();
        core_busy = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("post_reset_no_execute", {15'b0, execute}, 16'h0);
        end
    endtask

    task automatic checkDrained(input string name, input int startCount, input int expIssued);
        checkOutput({name, "_issue_count"}, 16'(execCount - startCount), 16'(expIssued));
        checkOutput({name, "_queue_empty"}, 16'(expQ.size()), 16'h0);
    endtask

    initial begin
        int startCount;

        vecs[0] = '{8'h00, 8'h00, 16'h0000};
        vecs[1] = '{8'hFF, 8'hFF, 16'hFFFF};
        vecs[2] = '{8'h80, 8'h01, 16'h8001};
        vecs[3] = '{8'h12, 8'h34, 16'h1234};
        vecs[4] = '{8'hDE, 8'hAD, 16'hDEAD};

        applyReset();

        // Single opcode with exact latency from the second strobe's E0.
        startCount = execCount;
        applyStimulus(8'hA5, 1'b0);
        expQ.push_back(16'hA53C);
        @(negedge clk);
        byte_in = 8'h3C;
        host_strobe = 1'b1;
        @(negedge clk);
        checkOutput("latency_n1", {15'b0, execute}, 16'h0);
        @(negedge clk);
        host_strobe = 1'b0;
        checkOutput("latency_n2", {15'b0, execute}, 16'h0);
        @(negedge clk);
        checkOutput("latency_n3", {15'b0, execute}, 16'h0);
        @(negedge clk);
        checkOutput("latency_e3", {15'b0, execute}, 16'h1);
        @(negedge clk);
        checkOutput("latency_single_pulse", {15'b0, execute}, 16'h0);
        repeat (4) @(negedge clk);
        checkDrained("single", startCount, 1);

        // Back-pressure: hold three opcodes, then release for back-to-back issue.
        startCount = execCount;
        core_busy = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(8'h00, 1'b0);
            applyStimulus(8'(i), 1'b0);
        end
        expQ.push_back(16'h0001);
        expQ.push_back(16'h0002);
        expQ.push_back(16'h0003);
        repeat (3) @(negedge clk);
        checkOutput("busy_no_issue", 16'(execCount - startCount), 16'h0);
        core_busy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("back_to_back_execute", {15'b0, execute}, 16'h1);
        end
        @(negedge clk);
        checkOutput("back_to_back_end", {15'b0, execute}, 16'h0);
        checkDrained("backpressure", startCount, 3);

        // Full and overflow: fifth opcode dropped, overflow sticky.
        startCount = execCount;
        core_busy = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(8'hC0, 1'b0);
            applyStimulus(8'(i), 1'b0);
            expQ.push_back(16'hC000 | 16'(i));
        end
        checkOutput("full_flag_set", {15'b0, fifo_full}, 16'h1);
        checkOutput("no_overflow_yet", {15'b0, overflow}, 16'h0);
        applyStimulus(8'hC0, 1'b0);
        applyStimulus(8'h05, 1'b0);
        checkOutput("overflow_set", {15'b0, overflow}, 16'h1);
        checkOutput("full_after_drop", {15'b0, fifo_full}, 16'h1);
        core_busy = 1'b0;
        @(negedge clk);
        checkOutput("full_clears_on_pop", {15'b0, fifo_full}, 16'h0);
        repeat (6) @(negedge clk);
        checkDrained("overflow", startCount, 4);
        checkOutput("overflow_sticky", {15'b0, overflow}, 16'h1);

        applyReset();

        // Frame sync between bytes, then frame sync coincident with a byte event.
        startCount = execCount;
        applyStimulus(8'h11, 1'b0);
        @(negedge clk);
        frame_sync = 1'b1;
        @(negedge clk);
        frame_sync = 1'b0;
        applyStimulus(8'h22, 1'b0);
        applyStimulus(8'h33, 1'b0);
        expQ.push_back(16'h2233);
        applyStimulus(8'h44, 1'b0);
        applyStimulus(8'h55, 1'b1);
        applyStimulus(8'h66, 1'b0);
        applyStimulus(8'h77, 1'b0);
        expQ.push_back(16'h6677);
        repeat (4) @(negedge clk);
        checkDrained("frame_sync", startCount, 2);

        // Half-assembled opcode must not survive reset.
        applyStimulus(8'h99, 1'b0);
        applyReset();

        // Table-driven opcode vectors.
        startCount = execCount;
        foreach (vecs[i]) begin
            expQ.push_back(vecs[i].expOpcode);
            applyStimulus(vecs[i].hiByte, 1'b0);
            applyStimulus(vecs[i].loByte, 1'b0);
        end
        repeat (4) @(negedge clk);
        checkDrained("table", startCount, 5);

        // Push and pop together while full: push kept, order preserved.
        startCount = execCount;
        core_busy = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(8'hB0, 1'b0);
            applyStimulus(8'(i), 1'b0);
            expQ.push_back(16'hB000 | 16'(i));
        end
        checkOutput("simul_full_before", {15'b0, fifo_full}, 16'h1);
        expQ.push_back(16'hB005);
        applyStimulus(8'hB0, 1'b0);
        @(negedge clk);
        byte_in = 8'h05;
        host_strobe = 1'b1;
        @(negedge clk);
        @(negedge clk);
        host_strobe = 1'b0;
        core_busy = 1'b0;
        @(negedge clk);
        checkOutput("simul_execute", {15'b0, execute}, 16'h1);
        checkOutput("simul_still_full", {15'b0, fifo_full}, 16'h1);
        checkOutput("simul_no_overflow", {15'b0, overflow}, 16'h0);
        repeat (8) @(negedge clk);
        checkDrained("simul", startCount, 5);
        checkOutput("simul_overflow_final", {15'b0, overflow}, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/opcode_fetch.md
# opcode_fetch

Host-side command front end of the GPU. Receives the RP2040's opcode stream one byte per strobe, assembles byte pairs into 16-bit opcodes and buffers them in a small FIFO. It then issues each opcode to `core_array` with a one-cycle `execute` pulse, honouring a back-pressure input from the core array. It sits directly upstream of `core_array` and replaces ad-hoc shift-register opcode collection at the top level.

## Interface

Parameters:
- `FIFO_DEPTH`, default 4: opcode FIFO entries; power of two, 2..16.

Ports:
- `clk`  input  1  GPU clock; all logic on rising edge.
- `rst_n`  input  1  reset, synchronous, active-low.
- `host_strobe`  input  1  byte strobe from RP2040. Asynchronous to `clk`; each rising edge delivers one byte.
- `byte_in`  input  8  host byte; `{ui_in[3:0], uio_in[3:0]}` at top level. Held stable by host around the strobe.
- `frame_sync`  input  1  synchronous to `clk`, active-high. Realigns byte phase.
- `core_busy`  input  1  high means the core array cannot accept an opcode this cycle.
- `opcode`  output  16  current opcode to core array; valid while `execute` is high.
- `execute`  output  1  one-cycle issue pulse.
- `fifo_full`  output  1  FIFO holds `FIFO_DEPTH` entries; host flow-control flag.
- `overflow`  output  1  sticky flag: a completed opcode was dropped.

## Operation

- **Strobe synchronizer.** `host_strobe` passes through two flops, `s0` then `s1`, plus a delay flop `s2`. A byte event is `s1 & ~s2`.
- **Byte assembly.**
  - A 1-bit `phase` register and an 8-bit `hi_byte` register handle assembly. Byte order is MSB first.
  - On a byte event with `phase`=0: `hi_byte` <= `byte_in`, `phase` <= 1.
  - On a byte event with `phase`=1: push `{hi_byte, byte_in}` to the FIFO, `phase` <= 0.
- **Frame sync.**
  - `frame_sync`=1 clears `phase` and discards any pending high byte.
  - FIFO contents are not touched.
  - If `frame_sync` and a byte event occur in the same cycle, `frame_sync` wins and the byte is discarded.
- **FIFO.**
  - Circular buffer: `FIFO_DEPTH` x 16, read/write pointers, count of 0..`FIFO_DEPTH`.
  - Pointers wrap modulo `FIFO_DEPTH`.
- **Push.**
  - A push when count < `FIFO_DEPTH` writes the entry.
  - A push when count = `FIFO_DEPTH` with no pop in the same cycle drops the word and sets `overflow`. `overflow` clears only on reset.
  - A push and pop in the same cycle are always accepted, including when the FIFO is full; count is unchanged.
- **Pop/issue.**
  - Each cycle with count > 0 and `core_busy`=0: `opcode` <= head entry, `execute` <= 1, head removed.
  - Otherwise `execute` <= 0 and `opcode` holds its last value.
  - Back-to-back issue every cycle is permitted.
- **`fifo_full`.** Registered; equals (next count == `FIFO_DEPTH`).
- **Reset values.**
  - Outputs: `opcode`=0, `execute`=0, `fifo_full`=0, `overflow`=0.
  - Internal state: count, pointers, `phase`, `hi_byte`, `s0`/`s1`/`s2` all 0.
  - Reset mid-operation discards FIFO contents and any half-assembled opcode.

## Timing

- **Edge labels.** E0 is the `clk` edge at which `s0` first samples `host_strobe` high.
- **Byte capture.**
  - The byte event is combinationally true in the cycle after E1.
  - `byte_in` is sampled at E2, so the host must hold it stable from before E0 through E2.
- **Issue latency.**
  - Second byte captured at E2 means the entry is visible in the FIFO after E2.
  - With an empty FIFO and `core_busy`=0, `execute` is high between E3 and E4: 3 cycles from E0.
- **Minimum strobe spacing.** Strobe high and low phases must each last at least 2 `clk` periods, giving at most one byte per 4 cycles. Faster strobes are outside spec.
- **`core_busy`.** Sampled in the same cycle as the pop decision, with no extra latency. Deasserting it with a non-empty FIFO gives `execute` on the next edge.
- **Flag timing.** `fifo_full` and `overflow` update on the edge where the push/pop takes effect.

## Test plan

- **Reset.** Assert `rst_n`=0 for 2 cycles with strobes active -> all outputs 0; no `execute` for 4 cycles after release.
- **Single opcode.** Bytes 0xA5 then 0x3C, `core_busy`=0 -> exactly one `execute` pulse, `opcode`=0xA53C, 3 cycles after the second strobe's E0.
- **Back-pressure.**
  - Push 3 opcodes (0x0001, 0x0002, 0x0003) with `core_busy`=1 -> no `execute`.
  - Then `core_busy`=0 -> 3 consecutive `execute` cycles, in order 0x0001, 0x0002, 0x0003.
- **Full/overflow** (`FIFO_DEPTH`=4).
  - With `core_busy`=1, push 4 opcodes -> `fifo_full`=1.
  - Push a 5th -> `overflow`=1, entry dropped.
  - Release `core_busy` -> 4 issued opcodes, 5th absent; `overflow` stays 1.
- **Frame sync.**
  - Send byte 0x11, pulse `frame_sync`, then send 0x22, 0x33 -> one opcode, 0x2233.
  - `frame_sync` coincident with a byte event -> that byte discarded.
- **Simultaneous push/pop at full.** Full FIFO, `core_busy` dropping in the same cycle as the push completes -> push accepted, count stays 4, no overflow, FIFO order preserved.
